// File: rtl/conv_layer_sequencer.sv
// Sequencer for one convolution layer pass: launches the indexing module, delay-matches MAC and
// feature-RAM controls, drains the pipeline and pulses done. Watchdog enabled by CONV_SEQ_WDOG_EN.
module conv_layer_sequencer #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAC_LAT  = 2,
  parameter int unsigned N_OFMAP  = 16,
  parameter int unsigned WDOG_CYC = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              Load_done,
  input  logic              Whole_done,
  input  logic              IMAGE_RAM_EN,
  input  logic              FILTER_RAM_EN,
  input  logic [ADDR_W-1:0] FEATURE_RAM_ADDR,
  output logic              Index_start,
  output logic              busy,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              FEATURE_WE,
  output logic [ADDR_W-1:0] FEATURE_WADDR,
  output logic              done,
  output logic              err
);

  localparam int unsigned PipeLat  = RD_LAT + MAC_LAT;
  localparam int unsigned LdW      = PipeLat + 1;
  localparam int unsigned DrainCnt = PipeLat + 1;
  localparam int unsigned DrnW     = $clog2(DrainCnt + 1);
  localparam int unsigned CntW     = ($clog2(N_OFMAP + 2) > 5) ? $clog2(N_OFMAP + 2) : 5;
  localparam logic [CntW-1:0] NOfmap = CntW'(N_OFMAP);
  localparam logic [CntW-1:0] NSat   = CntW'(N_OFMAP + 1);

  if (RD_LAT < 1 || RD_LAT > 4 || MAC_LAT < 1 || MAC_LAT > 4 || WDOG_CYC < 1) begin : g_param_chk
    $error("conv_layer_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {StIdle, StKick, StRun, StDrain, StFin} state_e;

  state_e            state_q, state_d;
  logic [DrnW-1:0]   drain_q, drain_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              first_q, first_d;
  logic              index_start_q, index_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] tap_sr_q, tap_sr_d;
  logic [LdW-1:0]    ld_sr_q, ld_sr_d;
  logic [ADDR_W-1:0] addr_sr_q [PipeLat];
  logic [ADDR_W-1:0] addr_sr_d [PipeLat];
  logic              gate_in, tap, ld, whole;

`ifdef CONV_SEQ_WDOG_EN
  localparam int unsigned WdW = $clog2(WDOG_CYC + 1);
  localparam logic [WdW-1:0] WdogLim = WdW'(WDOG_CYC);
  logic [WdW-1:0] wd_q, wd_d;
  logic           ign_q, ign_d;
  // After a watchdog trip, indexing inputs are dropped until the next accepted start.
  assign gate_in = ~ign_q;
`else
  assign gate_in = 1'b1;
`endif

  assign tap   = IMAGE_RAM_EN & FILTER_RAM_EN & gate_in;
  assign ld    = Load_done & gate_in;
  assign whole = Whole_done & gate_in;

  assign mac_en        = tap_sr_q[RD_LAT-1];
  assign FEATURE_WE    = ld_sr_q[PipeLat-1];
  assign FEATURE_WADDR = addr_sr_q[PipeLat-1];
  assign mac_clr       = ld_sr_q[PipeLat] | (first_q & mac_en);
  assign Index_start   = index_start_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    err_d    = err_q;
    first_d  = first_q & ~mac_en;
    wcnt_d   = wcnt_q;
`ifdef CONV_SEQ_WDOG_EN
    wd_d     = wd_q;
    ign_d    = ign_q;
`endif
    tap_sr_d = RD_LAT'({tap_sr_q, tap});
    ld_sr_d  = LdW'({ld_sr_q, ld});
    addr_sr_d[0] = ld ? FEATURE_RAM_ADDR : '0;
    for (int i = 1; i < PipeLat; i++) begin
      addr_sr_d[i] = addr_sr_q[i-1];
    end
    if (FEATURE_WE && (wcnt_q != NSat)) begin
      wcnt_d = wcnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StKick;
          err_d   = 1'b0;
          wcnt_d  = '0;
          first_d = 1'b1;
`ifdef CONV_SEQ_WDOG_EN
          ign_d   = 1'b0;
`endif
        end
      end
      StKick: begin
        state_d = StRun;
`ifdef CONV_SEQ_WDOG_EN
        wd_d    = WdW'(1);
`endif
      end
      StRun: begin
        if (whole) begin
          // The Whole_done cycle itself counts as the first drain cycle.
          state_d = StDrain;
          drain_d = DrnW'(PipeLat);
        end
`ifdef CONV_SEQ_WDOG_EN
        else if (ld) begin
          wd_d = WdW'(1);
        end else if ((wd_q + 1'b1) == WdogLim) begin
          err_d   = 1'b1;
          ign_d   = 1'b1;
          state_d = StDrain;
          drain_d = DrnW'(DrainCnt);
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      StDrain: begin
        if (drain_q <= DrnW'(1)) begin
          state_d = StFin;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
        if (wcnt_q != NOfmap) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    index_start_d = (state_d == StKick);
    busy_d        = (state_d == StKick) || (state_d == StRun) || (state_d == StDrain);
    done_d        = (state_d == StFin);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      drain_q       <= '0;
      wcnt_q        <= '0;
      err_q         <= 1'b0;
      first_q       <= 1'b0;
      index_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tap_sr_q      <= '0;
      ld_sr_q       <= '0;
      addr_sr_q     <= '{default: '0};
`ifdef CONV_SEQ_WDOG_EN
      wd_q          <= '0;
      ign_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      wcnt_q        <= wcnt_d;
      err_q         <= err_d;
      first_q       <= first_d;
      index_start_q <= index_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tap_sr_q      <= tap_sr_d;
      ld_sr_q       <= ld_sr_d;
      addr_sr_q     <= addr_sr_d;
`ifdef CONV_SEQ_WDOG_EN
      wd_q          <= wd_d;
      ign_q         <= ign_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: default instance plus an RD_LAT=2/MAC_LAT=1 instance
// driven by the same indexing stimulus. Watchdog steps run when CONV_SEQ_WDOG_EN is defined.
module tb_conv_layer_sequencer;

  logic       CLK = 1'b0;
  logic       RST, start, Load_done, Whole_done, IMAGE_RAM_EN, FILTER_RAM_EN;
  logic [4:0] FEATURE_RAM_ADDR;

  logic       index_start, busy, mac_en, mac_clr, fwe, done, err;
  logic [4:0] fwaddr;
  logic       index_start_r2, busy_r2, mac_en_r2, mac_clr_r2, fwe_r2, done_r2, err_r2;
  logic [4:0] fwaddr_r2;

  int n_assert = 0;
  int n_fail   = 0;
  int we_cnt, done_cnt, is_cnt, en_r2_cnt, both_r2_cnt;

  // Expected-value history of accepted indexing inputs (index 0 = previous cycle).
  logic [1:0] tap_h;
  logic [3:0] ld_h;
  logic [4:0] addr_h [3];
  logic       first1, first2, ign;

  always #5 CLK = ~CLK;

  conv_layer_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start), .Load_done(Load_done), .Whole_done(Whole_done),
    .IMAGE_RAM_EN(IMAGE_RAM_EN), .FILTER_RAM_EN(FILTER_RAM_EN),
    .FEATURE_RAM_ADDR(FEATURE_RAM_ADDR), .Index_start(index_start), .busy(busy),
    .mac_en(mac_en), .mac_clr(mac_clr), .FEATURE_WE(fwe), .FEATURE_WADDR(fwaddr),
    .done(done), .err(err)
  );

  conv_layer_sequencer #(.RD_LAT(2), .MAC_LAT(1)) dut_r2 (
    .CLK(CLK), .RST(RST), .start(start), .Load_done(Load_done), .Whole_done(Whole_done),
    .IMAGE_RAM_EN(IMAGE_RAM_EN), .FILTER_RAM_EN(FILTER_RAM_EN),
    .FEATURE_RAM_ADDR(FEATURE_RAM_ADDR), .Index_start(index_start_r2), .busy(busy_r2),
    .mac_en(mac_en_r2), .mac_clr(mac_clr_r2), .FEATURE_WE(fwe_r2), .FEATURE_WADDR(fwaddr_r2),
    .done(done_r2), .err(err_r2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic e_is, input logic e_busy,
                         input logic e_done);
    chk({tag, "_index_start"}, index_start, e_is);
    chk({tag, "_busy"}, busy, e_busy);
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_index_start_r2"}, index_start_r2, e_is);
    chk({tag, "_busy_r2"}, busy_r2, e_busy);
    chk({tag, "_done_r2"}, done_r2, e_done);
  endtask

  task automatic chk_err(input string tag, input logic e_err);
    chk(tag, err, e_err);
    chk({tag, "_r2"}, err_r2, e_err);
  endtask

  task automatic drive_in(input logic img, input logic fil, input logic ld, input logic wh,
                          input logic [4:0] ad);
    IMAGE_RAM_EN     = img;
    FILTER_RAM_EN    = fil;
    Load_done        = ld;
    Whole_done       = wh;
    FEATURE_RAM_ADDR = ad;
  endtask

  // Advance one cycle, update expected datapath history and check the delayed outputs.
  task automatic tick();
    logic       tp, l, r, e_clr1, e_clr2;
    logic [4:0] a;
    tp = IMAGE_RAM_EN & FILTER_RAM_EN & ~ign;
    l  = Load_done & ~ign;
    a  = l ? FEATURE_RAM_ADDR : 5'd0;
    r  = RST;
    @(negedge CLK);
    if (r) begin
      tap_h  = '0;
      ld_h   = '0;
      addr_h = '{default: '0};
      first1 = 1'b0;
      first2 = 1'b0;
      ign    = 1'b0;
    end else begin
      tap_h     = {tap_h[0], tp};
      ld_h      = {ld_h[2:0], l};
      addr_h[2] = addr_h[1];
      addr_h[1] = addr_h[0];
      addr_h[0] = a;
    end
    e_clr1 = ld_h[3] | (first1 & tap_h[0]);
    e_clr2 = ld_h[3] | (first2 & tap_h[1]);
    if (first1 && tap_h[0]) first1 = 1'b0;
    if (first2 && tap_h[1]) first2 = 1'b0;
    chk("mac_en", mac_en, tap_h[0]);
    chk("mac_clr", mac_clr, e_clr1);
    chk("feature_we", fwe, ld_h[2]);
    if (ld_h[2]) chk("feature_waddr", fwaddr, addr_h[2]);
    chk("mac_en_r2", mac_en_r2, tap_h[1]);
    chk("mac_clr_r2", mac_clr_r2, e_clr2);
    chk("feature_we_r2", fwe_r2, ld_h[2]);
    if (ld_h[2]) chk("feature_waddr_r2", fwaddr_r2, addr_h[2]);
    we_cnt      += int'(fwe);
    done_cnt    += int'(done);
    is_cnt      += int'(index_start);
    en_r2_cnt   += int'(mac_en_r2);
    both_r2_cnt += int'(mac_en_r2 & mac_clr_r2);
  endtask

  task automatic start_pass(input logic hold);
    we_cnt = 0; done_cnt = 0; is_cnt = 0; en_r2_cnt = 0; both_r2_cnt = 0;
    drive_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("index_start_before", index_start, 1'b0);
    start = 1'b1;
    tick();
    start  = hold;
    ign    = 1'b0;
    first1 = 1'b1;
    first2 = 1'b1;
    chk_ctl("kick", 1'b1, 1'b1, 1'b0);
    chk_err("err_cleared_by_start", 1'b0);
    tick();
    chk_ctl("run", 1'b0, 1'b1, 1'b0);
  endtask

  // 16 back-to-back 9-tap windows (one skipped if skip is 0..14), then drain and done.
  task automatic full_pass(input int skip, input logic hold);
    start_pass(hold);
    for (int w = 0; w < 16; w++) begin
      if (w == skip) continue;
      for (int t = 0; t < 9; t++) begin
        drive_in(1'b1, 1'b1, t == 8, (t == 8) && (w == 15), 5'(w));
        tick();
      end
    end
    drive_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_ctl("drain_wd1", 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk_ctl("drain_wd3", 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("fin_wd4", 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    chk_ctl("idle_after_fin", 1'b0, 1'b0, 1'b0);
    chk("done_count", done_cnt, 1);
    chk("index_start_count", is_cnt, 1);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; ign = 1'b0; first1 = 1'b0; first2 = 1'b0;
    tap_h = '0; ld_h = '0; addr_h = '{default: '0};
    we_cnt = 0; done_cnt = 0; is_cnt = 0; en_r2_cnt = 0; both_r2_cnt = 0;
    drive_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk_err("reset_err", 1'b0);
    chk("reset_waddr", fwaddr, 5'd0);
    RST = 1'b0;
    tick();

    // Nominal pass: 16 writes, no error; r2 instance sees 144 mac_en cycles and 16 clr+en.
    full_pass(-1, 1'b0);
    chk("t1_writes", we_cnt, 16);
    chk_err("t1_err", 1'b0);
    chk("t1_r2_mac_en_cycles", en_r2_cnt, 144);
    chk("t1_r2_clr_with_en", both_r2_cnt, 16);

    // One window skipped: 15 writes, err set after done.
    full_pass(5, 1'b0);
    chk("t2_writes", we_cnt, 15);
    chk_err("t2_err", 1'b1);

    // start held through RUN, DRAIN and FIN: one Index_start; start clears err.
    full_pass(-1, 1'b1);
    chk("t3_writes", we_cnt, 16);
    chk_err("t3_err", 1'b0);

    // RST two cycles after a Load_done discards the in-flight write.
    start_pass(1'b0);
    for (int t = 0; t < 9; t++) begin
      drive_in(1'b1, 1'b1, t == 8, 1'b0, 5'd7);
      tick();
    end
    drive_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_ctl("t4_after_rst", 1'b0, 1'b0, 1'b0);
    chk_err("t4_err", 1'b0);
    chk("t4_we", fwe, 1'b0);
    chk("t4_mac_en", mac_en, 1'b0);
    chk("t4_mac_clr", mac_clr, 1'b0);
    chk("t4_waddr", fwaddr, 5'd0);
    tick();
    tick();
    chk("t4_writes", we_cnt, 0);

`ifdef CONV_SEQ_WDOG_EN
    // Stall after three windows: err 64 cycles after the third Load_done, done 4 later.
    start_pass(1'b0);
    for (int w = 0; w < 3; w++) begin
      for (int t = 0; t < 9; t++) begin
        drive_in(1'b1, 1'b1, t == 8, 1'b0, 5'(w));
        tick();
      end
    end
    drive_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    repeat (62) tick();
    chk_err("t6_err_at_63", 1'b0);
    tick();
    chk_err("t6_err_at_64", 1'b1);
    chk_ctl("t6_drain", 1'b0, 1'b1, 1'b0);
    ign = 1'b1;
    drive_in(1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
    tick();
    drive_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    chk_ctl("t6_at_67", 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("t6_done_at_68", 1'b0, 1'b0, 1'b1);
    tick();
    chk("t6_writes", we_cnt, 3);
    chk("t6_done_count", done_cnt, 1);
    chk_err("t6_err_sticky", 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
